// File: rtl/interrupt_seq.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_seq
// Brief    : 6502-style interrupt/BRK entry sequencer: pushes PC and P, then
//            fetches the NMI or IRQ/BRK vector over a simple byte bus.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_seq #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        irq,
    input  logic        nmi,
    input  logic        brk_req,
    input  logic        boundary,
    input  logic [15:0] pc_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  din,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic [15:0] pc_out,
    output logic [7:0]  sp_out,
    output logic [7:0]  p_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DUMMY    = 3'd1,
        PUSH_PCH = 3'd2,
        PUSH_PCL = 3'd3,
        PUSH_P   = 3'd4,
        VEC_LO   = 3'd5,
        VEC_HI   = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t      state_q,    state_d;
    logic        nmi_prev_q;
    logic        nmi_pend_q, nmi_pend_d;
    logic [15:0] pc_q,       pc_d;
    logic [7:0]  sp_q,       sp_d;
    logic [7:0]  p_q,        p_d;
    logic        brk_q,      brk_d;
    logic        vec_nmi_q,  vec_nmi_d;
    logic [7:0]  pcl_q,      pcl_d;
    logic [15:0] pc_out_q,   pc_out_d;
    logic [7:0]  sp_out_q,   sp_out_d;
    logic [7:0]  p_out_q,    p_out_d;

    logic        w_nmi_edge;
    logic        w_start;
    logic [15:0] w_vec_base;
    logic [7:0]  w_p_push;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
            pc_q       <= 16'h0000;
            sp_q       <= 8'h00;
            p_q        <= 8'h00;
            brk_q      <= 1'b0;
            vec_nmi_q  <= 1'b0;
            pcl_q      <= 8'h00;
            pc_out_q   <= 16'h0000;
            sp_out_q   <= 8'h00;
            p_out_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            nmi_prev_q <= nmi;
            nmi_pend_q <= nmi_pend_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            p_q        <= p_d;
            brk_q      <= brk_d;
            vec_nmi_q  <= vec_nmi_d;
            pcl_q      <= pcl_d;
            pc_out_q   <= pc_out_d;
            sp_out_q   <= sp_out_d;
            p_out_q    <= p_out_d;
        end
    end

    always_comb begin
        w_nmi_edge = nmi & ~nmi_prev_q;
        w_start    = boundary & (nmi_pend_q | brk_req | (irq & ~p_in[2]));
        w_vec_base = vec_nmi_q ? NMI_VEC : IRQ_VEC;
        // Pushed status always has bit5 set; bit4 marks a software (BRK) entry
        w_p_push   = (p_q & 8'hCF) | 8'h20 | {3'b000, brk_q, 4'h0};

        state_d    = state_q;
        nmi_pend_d = nmi_pend_q | w_nmi_edge;
        pc_d       = pc_q;
        sp_d       = sp_q;
        p_d        = p_q;
        brk_d      = brk_q;
        vec_nmi_d  = vec_nmi_q;
        pcl_d      = pcl_q;
        pc_out_d   = pc_out_q;
        sp_out_d   = sp_out_q;
        p_out_d    = p_out_q;
        addr       = 16'h0000;
        dout       = 8'h00;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_start) begin
                    state_d = DUMMY;
                    pc_d    = pc_in;
                    sp_d    = sp_in;
                    p_d     = p_in;
                    brk_d   = ~nmi_pend_q & brk_req;
                end
            end
            DUMMY: begin
                busy    = 1'b1;
                state_d = PUSH_PCH;
            end
            PUSH_PCH: begin
                busy    = 1'b1;
                addr    = {STACK_PAGE, sp_q};
                dout    = pc_q[15:8];
                we      = 1'b1;
                sp_d    = sp_q - 8'd1;
                state_d = PUSH_PCL;
            end
            PUSH_PCL: begin
                busy    = 1'b1;
                addr    = {STACK_PAGE, sp_q};
                dout    = pc_q[7:0];
                we      = 1'b1;
                sp_d    = sp_q - 8'd1;
                state_d = PUSH_P;
            end
            PUSH_P: begin
                busy    = 1'b1;
                addr    = {STACK_PAGE, sp_q};
                dout    = w_p_push;
                we      = 1'b1;
                sp_d    = sp_q - 8'd1;
                state_d = VEC_LO;
            end
            VEC_LO: begin
                // A late NMI still wins here; a fresh edge this cycle stays pending
                busy      = 1'b1;
                vec_nmi_d = nmi_pend_q;
                addr      = nmi_pend_q ? NMI_VEC : IRQ_VEC;
                pcl_d     = din;
                if (nmi_pend_q) begin
                    nmi_pend_d = w_nmi_edge;
                end
                state_d   = VEC_HI;
            end
            VEC_HI: begin
                busy     = 1'b1;
                addr     = w_vec_base + 16'd1;
                pc_out_d = {din, pcl_q};
                sp_out_d = sp_q;
                p_out_d  = (p_q | 8'h24) & 8'hEF;
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc_out = pc_out_q;
    assign sp_out = sp_out_q;
    assign p_out  = p_out_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_seq
// Brief    : Self-checking bench for interrupt_seq with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_seq;

    localparam logic [7:0]  STACK_PAGE = 8'h01;
    localparam logic [15:0] NMI_VEC    = 16'hFFFA;
    localparam logic [15:0] IRQ_VEC    = 16'hFFFE;
    localparam int KIND_IRQ = 0;
    localparam int KIND_BRK = 1;
    localparam int KIND_NMI = 2;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        irq;
    logic        nmi;
    logic        brk_req;
    logic        boundary;
    logic [15:0] pc_in;
    logic [7:0]  sp_in;
    logic [7:0]  p_in;
    wire  [7:0]  din;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic        busy;
    logic        done;
    logic [15:0] pc_out;
    logic [7:0]  sp_out;
    logic [7:0]  p_out;

    logic [7:0]  mem [0:65535];
    int          n_vec = 0;
    int          n_err = 0;

    assign din = mem[addr];

    always #5 ph1 = ~ph1;

    interrupt_seq #(
        .STACK_PAGE (STACK_PAGE),
        .NMI_VEC    (NMI_VEC),
        .IRQ_VEC    (IRQ_VEC)
    ) u_dut (
        .ph1      (ph1),
        .reset    (reset),
        .irq      (irq),
        .nmi      (nmi),
        .brk_req  (brk_req),
        .boundary (boundary),
        .pc_in    (pc_in),
        .sp_in    (sp_in),
        .p_in     (p_in),
        .din      (din),
        .addr     (addr),
        .dout     (dout),
        .we       (we),
        .busy     (busy),
        .done     (done),
        .pc_out   (pc_out),
        .sp_out   (sp_out),
        .p_out    (p_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Keeps the CPU at a boundary with no source; nothing may start
    task automatic idle_check(input int n);
        boundary = 1'b1;
        irq      = 1'b0;
        brk_req  = 1'b0;
        repeat (n) begin
            @(negedge ph1);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_we", 32'(we), 32'd0);
        end
        boundary = 1'b0;
    endtask

    // One full entry; hij = busy-cycle index (1..4) in which nmi rises, 0 = none
    task automatic run_seq(input int kind, input logic [15:0] pc, input logic [7:0] sp,
                           input logic [7:0] p, input int hij);
        logic        brk_cls;
        logic        use_nmi;
        logic [15:0] vec;
        logic [15:0] vec1;
        logic [15:0] exp_pc;
        logic [7:0]  exp_sp_out;
        logic [7:0]  exp_p_out;
        logic [7:0]  wr_sp [3];
        logic [7:0]  wr_dat [3];

        brk_cls    = (kind == KIND_BRK);
        use_nmi    = (kind == KIND_NMI) || (hij >= 1 && hij <= 4);
        vec        = use_nmi ? NMI_VEC : IRQ_VEC;
        vec1       = vec + 16'd1;
        exp_pc     = {mem[vec1], mem[vec]};
        exp_sp_out = sp - 8'd3;
        exp_p_out  = (p | 8'h24) & 8'hEF;
        wr_sp[0]   = sp;
        wr_sp[1]   = sp - 8'd1;
        wr_sp[2]   = sp - 8'd2;
        wr_dat[0]  = pc[15:8];
        wr_dat[1]  = pc[7:0];
        wr_dat[2]  = (p & 8'hEF) | 8'h20 | (brk_cls ? 8'h10 : 8'h00);

        @(negedge ph1);
        pc_in = pc;
        sp_in = sp;
        p_in  = p;
        if (kind == KIND_NMI) begin
            nmi = 1'b1;
            @(negedge ph1);
        end
        boundary = 1'b1;
        irq      = (kind == KIND_IRQ);
        brk_req  = (kind == KIND_BRK);

        for (int c = 1; c <= 8; c++) begin
            @(negedge ph1);
            if (c == 1) begin
                boundary = 1'b0;
                irq      = 1'b0;
                brk_req  = 1'b0;
                pc_in    = 16'($urandom);
                sp_in    = 8'($urandom);
                p_in     = 8'($urandom);
            end
            if (c <= 6) begin
                check_eq("busy", 32'(busy), 32'd1);
                check_eq("we", 32'(we), 32'((c >= 2) && (c <= 4)));
                if (c >= 2 && c <= 4) begin
                    check_eq("push_addr", 32'(addr), 32'({STACK_PAGE, wr_sp[c-2]}));
                    check_eq("push_data", 32'(dout), 32'(wr_dat[c-2]));
                end
                if (c == 1) check_eq("dummy_addr", 32'(addr), 32'd0);
                if (c == 5) check_eq("vec_lo_addr", 32'(addr), 32'(vec));
                if (c == 6) check_eq("vec_hi_addr", 32'(addr), 32'(vec1));
            end else if (c == 7) begin
                check_eq("done", 32'(done), 32'd1);
                check_eq("done_busy", 32'(busy), 32'd0);
                check_eq("done_we", 32'(we), 32'd0);
                check_eq("done_addr", 32'(addr), 32'd0);
                check_eq("pc_out", 32'(pc_out), 32'(exp_pc));
                check_eq("sp_out", 32'(sp_out), 32'(exp_sp_out));
                check_eq("p_out", 32'(p_out), 32'(exp_p_out));
            end else begin
                check_eq("done_pulse", 32'(done), 32'd0);
                check_eq("pc_out_hold", 32'(pc_out), 32'(exp_pc));
            end
            if (c == hij) nmi = 1'b1;
        end
        nmi = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        irq      = 1'b0;
        nmi      = 1'b0;
        brk_req  = 1'b0;
        boundary = 1'b0;
        pc_in    = 16'h0000;
        sp_in    = 8'h00;
        p_in     = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFE] = 8'h00;
        mem[16'hFFFF] = 8'hF0;
        mem[16'hFFFA] = 8'h00;
        mem[16'hFFFB] = 8'hE0;

        repeat (3) @(negedge ph1);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_we", 32'(we), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pc_out", 32'(pc_out), 32'd0);
        check_eq("rst_sp_out", 32'(sp_out), 32'd0);
        check_eq("rst_p_out", 32'(p_out), 32'd0);
        reset = 1'b0;

        run_seq(KIND_IRQ, 16'h1234, 8'hFD, 8'h20, 0);

        // Masked IRQ
        @(negedge ph1);
        p_in     = 8'h24;
        irq      = 1'b1;
        boundary = 1'b1;
        repeat (20) begin
            @(negedge ph1);
            check_eq("masked_busy", 32'(busy), 32'd0);
            check_eq("masked_we", 32'(we), 32'd0);
        end
        irq      = 1'b0;
        boundary = 1'b0;

        run_seq(KIND_BRK, 16'hABCD, 8'h80, 8'h24, 0);
        run_seq(KIND_IRQ, 16'h5678, 8'hF0, 8'h20, 3);
        idle_check(4);
        run_seq(KIND_IRQ, 16'h0F0F, 8'h01, 8'h00, 0);

        // Reset in PUSH_PCL with an NMI pending
        @(negedge ph1);
        pc_in    = 16'h2222;
        sp_in    = 8'h40;
        p_in     = 8'h00;
        irq      = 1'b1;
        boundary = 1'b1;
        @(negedge ph1);
        irq      = 1'b0;
        boundary = 1'b0;
        nmi      = 1'b1;
        @(negedge ph1);
        @(negedge ph1);
        check_eq("pre_rst_we", 32'(we), 32'd1);
        #1;
        reset = 1'b1;
        nmi   = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_we", 32'(we), 32'd0);
        check_eq("mid_rst_addr", 32'(addr), 32'd0);
        check_eq("mid_rst_dout", 32'(dout), 32'd0);
        @(negedge ph1);
        reset = 1'b0;
        idle_check(4);
        run_seq(KIND_IRQ, 16'h3456, 8'hC0, 8'h01, 0);

        for (int it = 0; it < 40; it++) begin
            int          kind;
            int          hij;
            logic [7:0]  rp;
            mem[16'hFFFA] = 8'($urandom);
            mem[16'hFFFB] = 8'($urandom);
            mem[16'hFFFE] = 8'($urandom);
            mem[16'hFFFF] = 8'($urandom);
            kind = int'($urandom_range(0, 2));
            rp   = 8'($urandom);
            if (kind == KIND_IRQ) rp[2] = 1'b0;
            hij  = (kind == KIND_NMI) ? 0 : int'($urandom_range(0, 4));
            run_seq(kind, 16'($urandom), 8'($urandom), rp, hij);
            idle_check(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
